// File: rtl/counter_timer_arb_if.sv
// Requester-side bundle for the shared interval timer arbiter.
// slave = arbiter side, master = requester side.
interface counter_timer_arb_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             abort;
  logic             busy;

  modport master (
    output req0,
    output req1,
    output len0,
    output len1,
    input  gnt0,
    input  gnt1,
    input  done0,
    input  done1,
    input  abort,
    input  busy
  );

  modport slave (
    input  req0,
    input  req1,
    input  len0,
    input  len1,
    output gnt0,
    output gnt1,
    output done0,
    output done1,
    output abort,
    output busy
  );
endinterface

// File: rtl/counter_timer_arb.sv
// Two-requester arbiter sharing one free-running counter as an interval timer.
// Define TIMER_ARB_RR_EN for round-robin ties; default is fixed priority (req0).

// Free-running up counter with synchronous clear.
module counter_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  // Count up every clock unless held in clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= '0;
    else       r_q <= r_q + 1'b1;
  end

  assign o_q = r_q;
endmodule

module counter_timer_arb #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  counter_timer_arb_if.slave bus,
  output logic             o_cnt_clr,
  input  logic [WIDTH-1:0] i_cnt_q
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_owner;
  logic [WIDTH-1:0] r_len;
  logic             r_last;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic             r_abort;
  logic             r_busy;
  logic             r_cnt_clr;

  logic             w_req_any;
  logic             w_tie_win;
  logic             w_win;
  logic [WIDTH-1:0] w_win_len;
  logic             w_own_req;
  logic             w_hit;

  assign w_req_any = bus.req0 | bus.req1;

`ifdef TIMER_ARB_RR_EN
  // On a tie the requester that did not finish last goes next.
  assign w_tie_win = ~r_last;
`else
  // Fixed priority: req0 always takes a tie; last is tracked only.
  assign w_tie_win = 1'b0;
  logic w_unused_last;
  assign w_unused_last = r_last;
`endif

  assign w_win     = (bus.req0 & bus.req1) ? w_tie_win : bus.req1;
  assign w_win_len = w_win ? bus.len1 : bus.len0;
  assign w_own_req = r_owner ? bus.req1 : bus.req0;
  assign w_hit     = (i_cnt_q == r_len);

  // Arbitration / interval FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_len     <= '0;
      r_last    <= 1'b1;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_abort   <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt_clr <= 1'b1;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_abort <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_state   <= S_RUN;
            r_owner   <= w_win;
            r_len     <= w_win_len;
            r_gnt0    <= ~w_win;
            r_gnt1    <= w_win;
            r_busy    <= 1'b1;
            r_cnt_clr <= 1'b0;
          end
        end
        S_RUN: begin
          if (!w_own_req) begin
            r_state   <= S_IDLE;
            r_abort   <= 1'b1;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt_clr <= 1'b1;
          end else if (w_hit) begin
            r_state   <= S_DONE;
            r_done0   <= ~r_owner;
            r_done1   <= r_owner;
            r_cnt_clr <= 1'b1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_gnt0    <= 1'b0;
          r_gnt1    <= 1'b0;
          r_busy    <= 1'b0;
          r_cnt_clr <= 1'b1;
          r_last    <= r_owner;
        end
        default: begin
          r_state   <= S_IDLE;
          r_gnt0    <= 1'b0;
          r_gnt1    <= 1'b0;
          r_busy    <= 1'b0;
          r_cnt_clr <= 1'b1;
        end
      endcase
    end
  end

  assign bus.gnt0  = r_gnt0;
  assign bus.gnt1  = r_gnt1;
  assign bus.done0 = r_done0;
  assign bus.done1 = r_done1;
  assign bus.abort = r_abort;
  assign bus.busy  = r_busy;

  // Hold the counter cleared while reset is applied so it parks at 0
  // on the same edge as the rest of the block.
  assign o_cnt_clr = r_cnt_clr | i_reset;
endmodule

// File: tb/tb_counter_timer_arb.sv
// Scoreboard bench for counter_timer_arb driving a real counter_4bit.
// Stimulus queues expected grant/done/abort events; a monitor pops them.
module tb_counter_timer_arb;
  localparam int K_G0 = 0;
  localparam int K_G1 = 1;
  localparam int K_D0 = 2;
  localparam int K_D1 = 3;
  localparam int K_AB = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       cnt_clr;
  logic [3:0] cnt_q;
  int         cyc;
  int         errors;
  int         checks;
  int         gcyc;
  logic       p0;
  logic       p1;
  ev_t        exp_q[$];

  counter_timer_arb_if #(.WIDTH(4)) bus ();

  counter_timer_arb #(.WIDTH(4)) u_dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .bus       (bus),
    .o_cnt_clr (cnt_clr),
    .i_cnt_q   (cnt_q)
  );

  counter_4bit #(.WIDTH(4)) u_cnt (
    .i_clk (clk),
    .i_rst (cnt_clr),
    .o_q   (cnt_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc  = 0;
    gcyc = 0;
    p0   = 1'b0;
    p1   = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)",
               kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: every grant rise and every pulse consumes one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.gnt0 && !p0) begin
        gcyc = cyc;
        got(K_G0);
      end
      if (bus.gnt1 && !p1) begin
        gcyc = cyc;
        got(K_G1);
      end
      if (bus.done0) got(K_D0);
      if (bus.done1) got(K_D1);
      if (bus.abort) got(K_AB);
      if (bus.gnt0 || bus.gnt1)
        chk("gnt_exclusive", int'(bus.gnt0 & bus.gnt1), 0);
      if (bus.busy && !bus.done0 && !bus.done1)
        chk("cnt_q_run", int'(cnt_q), cyc - gcyc);
    end
    p0 = bus.gnt0;
    p1 = bus.gnt1;
  end

  task automatic step_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic idle_chk(input string name);
    chk({name, "_gnt0"}, int'(bus.gnt0), 0);
    chk({name, "_gnt1"}, int'(bus.gnt1), 0);
    chk({name, "_busy"}, int'(bus.busy), 0);
    chk({name, "_clr"}, int'(cnt_clr), 1);
  endtask

  task automatic run_one(input bit who, input logic [3:0] len);
    int g;
    int d;
    if (who) begin
      bus.req1 = 1'b1;
      bus.len1 = len;
    end else begin
      bus.req0 = 1'b1;
      bus.len0 = len;
    end
    g = cyc + 1;
    d = g + int'(len) + 1;
    push(who ? K_G1 : K_G0, g);
    push(who ? K_D1 : K_D0, d);
    step_to(g);
    if (who) bus.len1 = ~len;
    else     bus.len0 = ~len;
    step_to(d);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    idle_chk("after_done");
  endtask

  initial begin
    int g;
    int w[3];
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.len0 = 4'd0;
    bus.len1 = 4'd0;

    // 1: reset state, then idle with no request
    repeat (2) @(negedge clk);
    idle_chk("reset");
    chk("reset_cnt_q", int'(cnt_q), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    idle_chk("idle_noreq");

    // 2: requester 0, len 3
    run_one(1'b0, 4'd3);

    // 3: requester 1, len 0 and len 15
    run_one(1'b1, 4'd0);
    run_one(1'b1, 4'd15);

    // 4: both held, len 2 each
`ifdef TIMER_ARB_RR_EN
    w[0] = 0; w[1] = 1; w[2] = 0;
`else
    w[0] = 0; w[1] = 0; w[2] = 0;
`endif
    bus.len0 = 4'd2;
    bus.len1 = 4'd2;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    g = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      push(w[i] != 0 ? K_G1 : K_G0, g);
      push(w[i] != 0 ? K_D1 : K_D0, g + 3);
      if (i < 2) g = g + 5;
    end
    step_to(g + 3);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    idle_chk("tie_end");

    // 5: owner drops req mid-interval, pending req1 follows
    bus.req0 = 1'b1;
    bus.len0 = 4'd9;
    g = cyc + 1;
    push(K_G0, g);
    step_to(g);
    bus.req1 = 1'b1;
    bus.len1 = 4'd1;
    step_to(g + 2);
    chk("abort_pt_cnt", int'(cnt_q), 2);
    bus.req0 = 1'b0;
    push(K_AB, g + 3);
    push(K_G1, g + 4);
    push(K_D1, g + 6);
    step_to(g + 3);
    idle_chk("abort");
    step_to(g + 6);
    bus.req1 = 1'b0;
    @(negedge clk);

    // 6: reset mid-interval after last was set to 0
    run_one(1'b0, 4'd1);
    bus.req1 = 1'b1;
    bus.len1 = 4'd8;
    g = cyc + 1;
    push(K_G1, g);
    step_to(g + 4);
    chk("pre_reset_cnt", int'(cnt_q), 4);
    rst      = 1'b1;
    bus.req1 = 1'b0;
    @(negedge clk);
    idle_chk("mid_reset");
    chk("mid_reset_cnt", int'(cnt_q), 0);
    chk("mid_reset_pulse",
        int'(bus.done0 | bus.done1 | bus.abort), 0);
    rst      = 1'b0;
    bus.len0 = 4'd1;
    bus.len1 = 4'd1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    g = cyc + 1;
    push(K_G0, g);
    push(K_D0, g + 2);
    step_to(g + 2);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (3) @(negedge clk);
    idle_chk("final");
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
